// File: rtl/uart_alu_ctrl_if.sv
// Handshake bundle between the command sequencer and its UART receiver,
// ALU and UART transmitter. The sequencer side uses the slave modport.
interface uart_alu_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 6
);
    logic                  i_rx_done;
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic [DATA_WIDTH-1:0] i_alu_result;
    logic                  i_tx_done;
    logic [DATA_WIDTH-1:0] o_alu_a;
    logic [DATA_WIDTH-1:0] o_alu_b;
    logic [OP_WIDTH-1:0]   o_alu_op;
    logic                  o_tx_start;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_busy;
    logic                  o_timeout_err;
    logic                  o_overrun_err;

    modport slave (
        input  i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
        output o_busy, o_timeout_err, o_overrun_err
    );

    modport master (
        output i_rx_done, i_rx_data, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
        input  o_busy, o_timeout_err, o_overrun_err
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Command sequencer: gathers operand A, operand B and opcode bytes from the UART
// receiver, presents them to an external ALU and ships the result to the transmitter.
module uart_alu_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic           clk,
    input  logic           reset,
    uart_alu_ctrl_if.slave bus
);
    // state   | meaning
    // WAIT_A  | idle, waiting for operand A byte
    // WAIT_B  | operand A held, waiting for operand B (timed)
    // WAIT_OP | operands held, waiting for opcode byte (timed)
    // EXEC    | single settle cycle for the ALU on the new inputs
    // SEND    | result handed to transmitter, waiting for tx done
    typedef enum logic [4:0] {
        WAIT_A  = 5'b00001,
        WAIT_B  = 5'b00010,
        WAIT_OP = 5'b00100,
        EXEC    = 5'b01000,
        SEND    = 5'b10000
    } state_t;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] alu_a_q;
    logic [DATA_WIDTH-1:0] alu_b_q;
    logic [OP_WIDTH-1:0]   alu_op_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic                  tx_start_q;
    logic                  busy_q;
    logic                  timeout_err_q;
    logic                  overrun_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_A;
            cnt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            tx_start_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_err_q <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    cnt_q <= '0;
                    if (bus.i_rx_done) begin
                        alu_a_q <= bus.i_rx_data;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.i_rx_done) begin
                        alu_b_q <= bus.i_rx_data;
                        cnt_q   <= '0;
                        state_q <= WAIT_OP;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q         <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= WAIT_A;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WAIT_OP: begin
                    // A byte landing on the last counted cycle beats the timeout.
                    if (bus.i_rx_done) begin
                        alu_op_q <= bus.i_rx_data[OP_WIDTH-1:0];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q         <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= WAIT_A;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                EXEC: begin
                    tx_data_q     <= bus.i_alu_result;
                    tx_start_q    <= 1'b1;
                    overrun_err_q <= bus.i_rx_done;
                    state_q       <= SEND;
                end
                SEND: begin
                    overrun_err_q <= bus.i_rx_done;
                    if (bus.i_tx_done) begin
                        busy_q  <= 1'b0;
                        state_q <= WAIT_A;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign bus.o_alu_a       = alu_a_q;
    assign bus.o_alu_b       = alu_b_q;
    assign bus.o_alu_op      = alu_op_q;
    assign bus.o_tx_data     = tx_data_q;
    assign bus.o_tx_start    = tx_start_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_timeout_err = timeout_err_q;
    assign bus.o_overrun_err = overrun_err_q;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed scenarios plus randomized traffic, all checked
// every cycle against a command-level model of the sequencer.
module tb_uart_alu_ctrl;
    localparam int DW = 8;
    localparam int OW = 6;
    localparam int TO = 16;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_alu_ctrl_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

    uart_alu_ctrl #(.DATA_WIDTH(DW), .OP_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
        case (op)
            6'h20:   alu = a + b;
            6'h22:   alu = a - b;
            6'h24:   alu = a & b;
            6'h25:   alu = a | b;
            6'h26:   alu = a ^ b;
            default: alu = {2'b00, op} + a;
        endcase
    endfunction

    assign bus.i_alu_result = alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Command-level model: count of bytes gathered, idle time since the last
    // accepted byte, and whether a result is being computed or transmitted.
    logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
    logic [OW-1:0] m_op = '0;
    logic m_start = 0, m_busy = 0, m_tout = 0, m_over = 0;
    int   m_got = 0, m_idle = 0;
    bit   m_exec = 0, m_send = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a = '0; m_b = '0; m_op = '0; m_res = '0;
            m_start = 0; m_busy = 0; m_tout = 0; m_over = 0;
            m_got = 0; m_idle = 0; m_exec = 0; m_send = 0;
        end else begin
            m_start = 0; m_tout = 0; m_over = 0;
            if (m_exec) begin
                m_res   = alu(m_a, m_b, m_op);
                m_start = 1;
                m_exec  = 0;
                m_send  = 1;
                m_over  = bus.i_rx_done;
            end else if (m_send) begin
                m_over = bus.i_rx_done;
                if (bus.i_tx_done) m_send = 0;
            end else if (bus.i_rx_done) begin
                if (m_got == 0)      m_a  = bus.i_rx_data;
                else if (m_got == 1) m_b  = bus.i_rx_data;
                else                 m_op = bus.i_rx_data[OW-1:0];
                m_idle = 0;
                if (m_got == 2) begin
                    m_got  = 0;
                    m_exec = 1;
                end else begin
                    m_got++;
                end
            end else if (m_got > 0) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_got  = 0;
                    m_idle = 0;
                    m_tout = 1;
                end
            end
            m_busy = m_exec | m_send;
        end
    end

    always @(negedge clk) begin
        check("cyc_alu_a",    bus.o_alu_a,       m_a);
        check("cyc_alu_b",    bus.o_alu_b,       m_b);
        check("cyc_alu_op",   bus.o_alu_op,      m_op);
        check("cyc_tx_data",  bus.o_tx_data,     m_res);
        check("cyc_tx_start", bus.o_tx_start,    m_start);
        check("cyc_busy",     bus.o_busy,        m_busy);
        check("cyc_timeout",  bus.o_timeout_err, m_tout);
        check("cyc_overrun",  bus.o_overrun_err, m_over);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [DW-1:0] b);
        bus.i_rx_done = 1'b1;
        bus.i_rx_data = b;
        tick();
        bus.i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    initial begin
        int pulses;
        int first_at;
        int pct;
        bus.i_rx_done = 1'b0;
        bus.i_rx_data = '0;
        bus.i_tx_done = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_alu_a",    bus.o_alu_a,    8'h00);
        check("rst_tx_data",  bus.o_tx_data,  8'h00);
        check("rst_tx_start", bus.o_tx_start, 1'b0);
        check("rst_busy",     bus.o_busy,     1'b0);

        // Basic add command: start strobe 2 clk after opcode strobe.
        send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
        check("t1_alu_a",  bus.o_alu_a,  8'h05);
        check("t1_alu_b",  bus.o_alu_b,  8'h03);
        check("t1_alu_op", bus.o_alu_op, 6'h20);
        check("t1_busy_exec", bus.o_busy, 1'b1);
        check("t1_start_early", bus.o_tx_start, 1'b0);
        tick();
        check("t1_start", bus.o_tx_start, 1'b1);
        check("t1_tx_data", bus.o_tx_data, 8'h08);
        check("t1_model_res", m_res, 8'h08);
        tick();
        check("t1_start_once", bus.o_tx_start, 1'b0);
        check("t1_busy_send", bus.o_busy, 1'b1);
        pulse_tx_done();
        check("t1_busy_low", bus.o_busy, 1'b0);

        // Timeout after a lone operand A.
        send_byte(8'h11);
        pulses = 0; first_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (bus.o_timeout_err) begin
                pulses++;
                if (first_at < 0) first_at = k;
            end
        end
        check("t2_tout_pulses", pulses, 1);
        check("t2_tout_delay", first_at, 16);
        send_byte(8'h02); send_byte(8'h04); send_byte(8'h20);
        tick();
        check("t2_tx_data", bus.o_tx_data, 8'h06);
        check("t2_start", bus.o_tx_start, 1'b1);
        tick();
        pulse_tx_done();

        // Opcode arriving on the exact timeout cycle still executes.
        send_byte(8'h30); send_byte(8'h07);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.o_timeout_err) pulses++;
        end
        send_byte(8'h22);
        check("t3_no_tout_wait", pulses, 0);
        check("t3_no_tout_edge", bus.o_timeout_err, 1'b0);
        check("t3_busy", bus.o_busy, 1'b1);
        tick();
        check("t3_start", bus.o_tx_start, 1'b1);
        check("t3_tx_data", bus.o_tx_data, 8'h29);
        check("t3_no_tout_late", bus.o_timeout_err, 1'b0);
        tick();
        pulse_tx_done();

        // Overrun during SEND.
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h25);
        tick(); tick();
        send_byte(8'hAA);
        check("t4_overrun", bus.o_overrun_err, 1'b1);
        check("t4_alu_a_kept", bus.o_alu_a, 8'h10);
        check("t4_tx_data", bus.o_tx_data, 8'h30);
        tick();
        check("t4_overrun_once", bus.o_overrun_err, 1'b0);
        pulse_tx_done();
        send_byte(8'h09); send_byte(8'h04); send_byte(8'h26);
        tick();
        check("t4_next_data", bus.o_tx_data, 8'h0D);
        tick();
        pulse_tx_done();

        // Async reset mid-SEND.
        send_byte(8'h05); send_byte(8'h03); send_byte(8'h20);
        tick();
        check("t5_pre_data", bus.o_tx_data, 8'h08);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_data",  bus.o_tx_data,  8'h00);
        check("t5_rst_busy",  bus.o_busy,     1'b0);
        check("t5_rst_start", bus.o_tx_start, 1'b0);
        check("t5_rst_alu_a", bus.o_alu_a,    8'h00);
        check("t5_rst_alu_op", bus.o_alu_op,  6'h00);
        @(posedge clk);
        #1 reset = 1'b0;
        pulse_tx_done();
        check("t5_spurious_busy", bus.o_busy, 1'b0);
        check("t5_spurious_start", bus.o_tx_start, 1'b0);

        // Opcode truncation to OP_WIDTH bits.
        send_byte(8'h01);
        check("t6_alu_a", bus.o_alu_a, 8'h01);
        send_byte(8'h02); send_byte(8'hFF);
        check("t6_alu_op", bus.o_alu_op, 6'h3F);
        tick();
        check("t6_tx_data", bus.o_tx_data, 8'h40);
        tick();
        pulse_tx_done();

        // Randomized traffic with varying byte density and rare async resets.
        pct = 12;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 3;
                    1:       pct = 12;
                    default: pct = 40;
                endcase
            end
            bus.i_rx_done = ($urandom_range(0, 99) < pct);
            bus.i_rx_data = DW'($urandom_range(0, 255));
            bus.i_tx_done = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                @(posedge clk);
                #1 reset = 1'b0;
            end else begin
                tick();
            end
        end
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Command sequencer between uart_rx, a combinational ALU and uart_tx.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them onto the ALU inputs.
- Latches the ALU result and hands it to the transmitter with a start/done handshake.
- Aborts half-received commands on an inter-byte timeout and flags bytes that arrive while it is busy.

Parameters:
- DATA_WIDTH, 8: width of UART bytes, ALU operands and ALU result.
- OP_WIDTH, 6: ALU opcode width; taken from the low OP_WIDTH bits of the opcode byte.
- TIMEOUT_CYCLES, 100000: clk cycles allowed between bytes of one command; legal range >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_rx_done  in  1  one-cycle strobe from receiver: i_rx_data valid.
- i_rx_data  in  DATA_WIDTH  received byte.
- i_alu_result  in  DATA_WIDTH  combinational ALU result for current o_alu_a/o_alu_b/o_alu_op.
- i_tx_done  in  1  one-cycle strobe from transmitter: byte fully sent.
- o_alu_a  out  DATA_WIDTH  registered operand A.
- o_alu_b  out  DATA_WIDTH  registered operand B.
- o_alu_op  out  OP_WIDTH  registered opcode.
- o_tx_start  out  1  one-cycle strobe requesting transmission of o_tx_data.
- o_tx_data  out  DATA_WIDTH  latched result; stable from o_tx_start until i_tx_done.
- o_busy  out  1  high in EXEC and SEND.
- o_timeout_err  out  1  one-cycle strobe: partial command discarded.
- o_overrun_err  out  1  one-cycle strobe: byte received while busy and dropped.

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0 immediately; state = WAIT_A; timeout counter = 0.
  - Reset mid-command or mid-send discards everything.
  - Release of reset is synchronous to clk.
- All outputs are registered. States are one-hot: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND.
- WAIT_A:
  - On i_rx_done: o_alu_a <= i_rx_data; counter <= 0; go to WAIT_B.
  - Counter is held at 0 in this state; no timeout.
- WAIT_B:
  - On i_rx_done: o_alu_b <= i_rx_data; counter <= 0; go to WAIT_OP.
  - Otherwise counter increments by 1 each clk.
- WAIT_OP:
  - On i_rx_done: o_alu_op <= i_rx_data[OP_WIDTH-1:0]; go to EXEC.
  - Otherwise counter increments by 1 each clk.
- Timeout (WAIT_B or WAIT_OP):
  - Counter value TIMEOUT_CYCLES-1 with no i_rx_done: go to WAIT_A, counter <= 0, o_timeout_err = 1 for the next cycle.
  - Operand registers keep their old values.
  - If i_rx_done coincides with the timeout cycle, the byte wins: no timeout, normal advance.
  - Counter width is clog2(TIMEOUT_CYCLES); no wrap-around is possible.
- EXEC:
  - Lasts exactly 1 cycle, which lets the ALU settle on the new registered inputs.
  - At its closing edge: o_tx_data <= i_alu_result; o_tx_start <= 1; go to SEND.
- SEND:
  - o_tx_start is high only in the first SEND cycle.
  - Wait for i_tx_done, then go to WAIT_A.
  - o_tx_data holds its value until the next EXEC.
  - An i_tx_done seen in any other state is ignored.
- Busy drop:
  - i_rx_done in EXEC or SEND: byte dropped, o_overrun_err = 1 for the next cycle, state unaffected.
- Latency:
  - Opcode byte's i_rx_done at edge N: EXEC during cycle N..N+1, o_tx_start high in cycle N+1..N+2.
  - Total is 2 clk from opcode strobe to start strobe.
- o_busy = (state == EXEC) | (state == SEND), registered with the state.
- ALU operands change only on accepted bytes, never in EXEC or SEND.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 with ALU model A+B -> o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20, o_tx_data=0x08, o_tx_start exactly 1 cycle, 2 clk after the third i_rx_done; i_tx_done returns state to WAIT_A and o_busy falls.
- TIMEOUT_CYCLES=16: send 0x11, then 20 idle clk -> o_timeout_err pulses once, 16 clk after the byte; a following 0x02, 0x04, 0x20 yields o_tx_data=0x06.
- i_rx_done on exactly the timeout cycle in WAIT_OP -> no o_timeout_err, command executes.
- Byte 0xAA arrives during SEND (before i_tx_done) -> o_overrun_err pulses once; o_alu_a unchanged; the next command after i_tx_done executes normally.
- Assert reset asynchronously (between edges) while in SEND with o_tx_data=0x08 -> all outputs 0 immediately; a later spurious i_tx_done is ignored; state is WAIT_A.
- Opcode byte 0xFF with OP_WIDTH=6 -> o_alu_op=0x3F.
